// File: rtl/rlbp_pixel_sequencer.sv
// RLBP pixel sequencer: steps the analog macro through N_PD photodiode
// pairs, samples the comparator per pair and hands off the packed code.
module rlbp_pixel_sequencer #(
   parameter int N_PD  = 12,
   parameter int CNT_W = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             start_i,
   input  logic             cont_i,
   input  logic [CNT_W-1:0] t_rst_i,
   input  logic [CNT_W-1:0] t_int_i,
   input  logic [CNT_W-1:0] t_cmp_i,
   input  logic             cmp_i,
   output logic [N_PD-1:0]  pd_a_o,
   output logic [N_PD-1:0]  pd_b_o,
   output logic             sh_rst_o,
   output logic             sw1_o,
   output logic             sh_o,
   output logic             sh_cmp_o,
   output logic             busy_o,
   output logic [N_PD-1:0]  code_o,
   output logic             code_valid_o,
   input  logic             code_ready_i,
   output logic             overrun_o,
   input  logic             clr_ovr_i
);

   localparam int KW = $clog2(N_PD);

   typedef enum logic [2:0] {
      S_IDLE, S_RST, S_INT, S_SMP, S_CMP, S_GAP, S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] tr_q, tr_d, ti_q, ti_d, tc_q, tc_d;
   logic [N_PD-1:0]  shift_q, shift_d;
   logic [N_PD-1:0]  code_q, code_d;
   logic             valid_q, valid_d;
   logic             ovr_q, ovr_d;
   logic             cmp_s1_q, cmp_s2_q;

   logic [CNT_W-1:0] tr_c, ti_c, tc_c;
   logic             last, xfer, ovr_set, in_pair;

   // Clamped phase lengths; compare phase covers synchronizer latency.
   always_comb begin
      tr_c = (t_rst_i == '0) ? CNT_W'(1) : t_rst_i;
      ti_c = (t_int_i == '0) ? CNT_W'(1) : t_int_i;
      tc_c = (t_cmp_i < CNT_W'(3)) ? CNT_W'(3) : t_cmp_i;
   end

   // Two-flop synchronizer for the asynchronous comparator output.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         cmp_s1_q <= 1'b0;
         cmp_s2_q <= 1'b0;
      end else begin
         cmp_s1_q <= cmp_i;
         cmp_s2_q <= cmp_s1_q;
      end
   end

   // Next-state logic: phase sequencing, code capture and handshake.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      tr_d    = tr_q;
      ti_d    = ti_q;
      tc_d    = tc_q;
      shift_d = shift_q;
      code_d  = code_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      ovr_set = 1'b0;
      last    = (cnt_q == '0);
      xfer    = valid_q & code_ready_i;
      if (xfer) valid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               tr_d    = tr_c;
               ti_d    = ti_c;
               tc_d    = tc_c;
               k_d     = '0;
               shift_d = '0;
               cnt_d   = tr_c - CNT_W'(1);
               state_d = S_RST;
            end
         end
         S_RST: begin
            if (last) begin
               cnt_d   = ti_q - CNT_W'(1);
               state_d = S_INT;
            end else cnt_d = cnt_q - CNT_W'(1);
         end
         S_INT: begin
            if (last) state_d = S_SMP;
            else cnt_d = cnt_q - CNT_W'(1);
         end
         S_SMP: begin
            cnt_d   = tc_q - CNT_W'(1);
            state_d = S_CMP;
         end
         S_CMP: begin
            if (last) begin
               shift_d[k_q] = cmp_s2_q;
               state_d      = S_GAP;
            end else cnt_d = cnt_q - CNT_W'(1);
         end
         S_GAP: begin
            if (k_q == KW'(N_PD - 1)) state_d = S_DONE;
            else begin
               k_d     = k_q + KW'(1);
               cnt_d   = tr_q - CNT_W'(1);
               state_d = S_RST;
            end
         end
         S_DONE: begin
            if (!valid_q || xfer) begin
               code_d  = shift_q;
               valid_d = 1'b1;
            end else ovr_set = 1'b1;
            if (cont_i) begin
               tr_d    = tr_c;
               ti_d    = ti_c;
               tc_d    = tc_c;
               k_d     = '0;
               shift_d = '0;
               cnt_d   = tr_c - CNT_W'(1);
               state_d = S_RST;
            end else state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (clr_ovr_i) ovr_d = 1'b0;
      else if (ovr_set) ovr_d = 1'b1;
   end

   // State and datapath registers.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cnt_q   <= '0;
         tr_q    <= '0;
         ti_q    <= '0;
         tc_q    <= '0;
         shift_q <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         tr_q    <= tr_d;
         ti_q    <= ti_d;
         tc_q    <= tc_d;
         shift_q <= shift_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   // Controls decode straight from the state register so reset kills them at once.
   always_comb begin
      in_pair      = (state_q == S_RST) || (state_q == S_INT) ||
                     (state_q == S_SMP) || (state_q == S_CMP);
      pd_a_o       = in_pair ? (N_PD'(1) << k_q) : '0;
      pd_b_o       = pd_a_o;
      sh_rst_o     = (state_q == S_RST);
      sw1_o        = (state_q == S_INT);
      sh_o         = (state_q == S_SMP);
      sh_cmp_o     = (state_q == S_CMP);
      busy_o       = (state_q != S_IDLE);
      code_o       = code_q;
      code_valid_o = valid_q;
      overrun_o    = ovr_q;
   end

endmodule

// File: tb/tb_rlbp_pixel_sequencer.sv
// Self-checking bench for rlbp_pixel_sequencer.
// Expected codes are queued at frame start and popped when a code appears.
module tb_rlbp_pixel_sequencer;

   localparam int N = 12;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic         cont_i = 1'b0;
   logic [7:0]   t_rst_i = '0;
   logic [7:0]   t_int_i = '0;
   logic [7:0]   t_cmp_i = '0;
   logic         cmp_i;
   logic         code_ready_i = 1'b0;
   logic         clr_ovr_i = 1'b0;
   logic [N-1:0] pd_a_o, pd_b_o, code_o;
   logic         sh_rst_o, sw1_o, sh_o, sh_cmp_o;
   logic         busy_o, code_valid_o, overrun_o;

   int           n_chk = 0;
   int           n_fail = 0;
   int           oh_err = 0;
   int           cyc_cnt = 0;
   logic [N-1:0] pat = '0;
   logic [N-1:0] exp_q[$];

   rlbp_pixel_sequencer #(.N_PD(N), .CNT_W(8)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
      .start_i(start_i), .cont_i(cont_i),
      .t_rst_i(t_rst_i), .t_int_i(t_int_i), .t_cmp_i(t_cmp_i),
      .cmp_i(cmp_i),
      .pd_a_o(pd_a_o), .pd_b_o(pd_b_o),
      .sh_rst_o(sh_rst_o), .sw1_o(sw1_o), .sh_o(sh_o), .sh_cmp_o(sh_cmp_o),
      .busy_o(busy_o), .code_o(code_o), .code_valid_o(code_valid_o),
      .code_ready_i(code_ready_i), .overrun_o(overrun_o),
      .clr_ovr_i(clr_ovr_i)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Comparator model: pair k of the current frame answers pat[k].
   always @* begin
      cmp_i = 1'b0;
      for (int i = 0; i < N; i++) if (pd_a_o[i]) cmp_i = pat[i];
   end

   // Select vectors one-hot and identical, controls mutually exclusive.
   always @(negedge clk)
      if (rst_n && (!$onehot0(pd_a_o) || pd_b_o !== pd_a_o ||
          !$onehot0({sh_rst_o, sw1_o, sh_o, sh_cmp_o})))
         oh_err <= oh_err + 1;

   function automatic logic [3*N+6:0] outs();
      return {pd_a_o, pd_b_o, sh_rst_o, sw1_o, sh_o, sh_cmp_o,
              busy_o, code_o, code_valid_o, overrun_o};
   endfunction

   task automatic start_frame(input logic [7:0] tr, ti, tc,
                              output int t0);
      @(negedge clk);
      t_rst_i = tr; t_int_i = ti; t_cmp_i = tc;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      t0 = cyc_cnt;
   endtask

   task automatic wait_valid(input int budget);
      int n = 0;
      while (!code_valid_o && n < budget) begin
         @(negedge clk); n++;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy_o && n < budget) begin
         @(negedge clk); n++;
      end
   endtask

   task automatic test_reset();
      int t0, n;
      #12;
      n_chk++;
      if (outs() !== '0) begin
         n_fail++;
         $display("FAIL reset_state: outs=%h required 0", outs());
      end
      @(negedge clk); rst_n = 1'b1;
      start_frame(8'd2, 8'd4, 8'd3, t0);
      n = 0;
      while (!sw1_o && n < 50) begin
         @(negedge clk); n++;
      end
      n_chk++;
      if (sw1_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reach_int: sw1_o=%b required 1", sw1_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_chk++;
      if (outs() !== '0) begin
         n_fail++;
         $display("FAIL async_reset: outs=%h required 0", outs());
      end
      @(negedge clk); rst_n = 1'b1;
      start_frame(8'd2, 8'd4, 8'd3, t0);
      n_chk++;
      if (pd_a_o !== 12'h001 || sh_rst_o !== 1'b1 || busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_pair0: pd_a=%h sh_rst=%b busy=%b required 001 1 1",
                  pd_a_o, sh_rst_o, busy_o);
      end
      #2 rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_code_aaa();
      int t0, lat, oh0;
      logic [N-1:0] e, got;
      for (int k = 0; k < N; k++) pat[k] = k[0];
      e = '0;
      for (int k = 0; k < N; k++) e[k] = k[0];
      exp_q.push_back(e);
      oh0 = oh_err;
      start_frame(8'd2, 8'd4, 8'd3, t0);
      wait_valid(400);
      lat = cyc_cnt - t0;
      n_chk++;
      if (code_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL aaa_valid: code_valid_o=%b required 1", code_valid_o);
      end
      // 12 pairs of 2+4+3+2 cycles, then the DONE cycle
      n_chk++;
      if (lat != N * 11 + 1) begin
         n_fail++;
         $display("FAIL aaa_latency: got %0d required %0d", lat, N * 11 + 1);
      end
      got = exp_q.pop_front();
      n_chk++;
      if (code_o !== got || got !== 12'hAAA) begin
         n_fail++;
         $display("FAIL aaa_code: code_o=%h required %h", code_o, got);
      end
      n_chk++;
      if (oh_err != oh0) begin
         n_fail++;
         $display("FAIL onehot: %0d bad cycles required 0", oh_err - oh0);
      end
      code_ready_i = 1'b1; @(negedge clk); code_ready_i = 1'b0;
      n_chk++;
      if (code_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL aaa_consume: code_valid_o=%b required 0", code_valid_o);
      end
   endtask

   task automatic test_min_timing();
      int t0, lat, got[5];
      int req[5] = '{1, 1, 1, 3, 1};
      logic [3:0] ctl;
      logic [N-1:0] e;
      pat = 12'h3C5;
      exp_q.push_back(12'h3C5);
      start_frame(8'd0, 8'd0, 8'd0, t0);
      for (int p = 0; p < 5; p++) begin
         got[p] = 0;
         ctl = {sh_cmp_o, sh_o, sw1_o, sh_rst_o};
         while (got[p] < 20 &&
                ((p < 4) ? ctl[p] : (ctl == 4'b0 && busy_o))) begin
            @(negedge clk); got[p]++;
            ctl = {sh_cmp_o, sh_o, sw1_o, sh_rst_o};
         end
      end
      for (int p = 0; p < 5; p++) begin
         n_chk++;
         if (got[p] != req[p]) begin
            n_fail++;
            $display("FAIL phase_len[%0d]: got %0d required %0d", p, got[p], req[p]);
         end
      end
      wait_valid(300);
      lat = cyc_cnt - t0;
      n_chk++;
      if (code_valid_o !== 1'b1 || lat != 85) begin
         n_fail++;
         $display("FAIL min_frame: valid=%b latency %0d required 1 85", code_valid_o, lat);
      end
      e = exp_q.pop_front();
      n_chk++;
      if (code_o !== e) begin
         n_fail++;
         $display("FAIL min_code: code_o=%h required %h", code_o, e);
      end
      code_ready_i = 1'b1; @(negedge clk); code_ready_i = 1'b0;
      wait_idle(10);
   endtask

   task automatic test_overrun();
      int t0;
      logic [N-1:0] e;
      cont_i = 1'b1;
      pat = 12'h5A5;
      exp_q.push_back(12'h5A5);
      start_frame(8'd2, 8'd4, 8'd3, t0);
      wait_valid(400);
      pat = 12'h123;
      cont_i = 1'b0;
      wait_idle(400);
      n_chk++;
      if (busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_idle: busy_o=%b required 0", busy_o);
      end
      e = exp_q.pop_front();
      n_chk++;
      if (overrun_o !== 1'b1 || code_o !== e || code_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ovr_set: ovr=%b code=%h valid=%b required 1 %h 1",
                  overrun_o, code_o, code_valid_o, e);
      end
      clr_ovr_i = 1'b1; @(negedge clk); clr_ovr_i = 1'b0;
      n_chk++;
      if (overrun_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_clear: overrun_o=%b required 0", overrun_o);
      end
      code_ready_i = 1'b1; @(negedge clk); code_ready_i = 1'b0;
      n_chk++;
      if (code_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_consume: code_valid_o=%b required 0", code_valid_o);
      end
   endtask

   task automatic test_ready_in_done();
      int t0;
      logic [N-1:0] e;
      cont_i = 1'b1;
      pat = 12'h0F0;
      exp_q.push_back(12'h0F0);
      start_frame(8'd2, 8'd4, 8'd3, t0);
      wait_valid(400);
      pat = 12'h9C3;
      cont_i = 1'b0;
      exp_q.push_back(12'h9C3);
      repeat (N * 11) @(negedge clk);
      e = exp_q.pop_front();
      n_chk++;
      if (code_valid_o !== 1'b1 || code_o !== e) begin
         n_fail++;
         $display("FAIL done_hold: valid=%b code=%h required 1 %h",
                  code_valid_o, code_o, e);
      end
      code_ready_i = 1'b1; @(negedge clk); code_ready_i = 1'b0;
      e = exp_q.pop_front();
      n_chk++;
      if (code_valid_o !== 1'b1 || overrun_o !== 1'b0 || code_o !== e) begin
         n_fail++;
         $display("FAIL done_xfer: valid=%b ovr=%b code=%h required 1 0 %h",
                  code_valid_o, overrun_o, code_o, e);
      end
      wait_idle(20);
      code_ready_i = 1'b1; @(negedge clk); code_ready_i = 1'b0;
   endtask

   task automatic test_start_held();
      int t0, lat;
      logic [N-1:0] e;
      cont_i = 1'b1;
      pat = 12'h6D2;
      exp_q.push_back(12'h6D2);
      @(negedge clk);
      t_rst_i = 8'd2; t_int_i = 8'd4; t_cmp_i = 8'd3;
      start_i = 1'b1;
      @(negedge clk);
      t0 = cyc_cnt;
      wait_valid(400);
      lat = cyc_cnt - t0;
      n_chk++;
      if (code_valid_o !== 1'b1 || lat != N * 11 + 1) begin
         n_fail++;
         $display("FAIL held_latency: valid=%b latency %0d required 1 %0d",
                  code_valid_o, lat, N * 11 + 1);
      end
      e = exp_q.pop_front();
      n_chk++;
      if (code_o !== e) begin
         n_fail++;
         $display("FAIL held_code1: code_o=%h required %h", code_o, e);
      end
      pat = 12'h2B4;
      exp_q.push_back(12'h2B4);
      code_ready_i = 1'b1; @(negedge clk); code_ready_i = 1'b0;
      repeat (20) @(negedge clk);
      start_i = 1'b0;
      cont_i = 1'b0;
      wait_idle(400);
      n_chk++;
      if (busy_o !== 1'b0 || code_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL held_stop: busy=%b valid=%b required 0 1", busy_o, code_valid_o);
      end
      e = exp_q.pop_front();
      n_chk++;
      if (code_o !== e) begin
         n_fail++;
         $display("FAIL held_code2: code_o=%h required %h", code_o, e);
      end
      repeat (40) @(negedge clk);
      n_chk++;
      if (busy_o !== 1'b0 || sh_rst_o !== 1'b0) begin
         n_fail++;
         $display("FAIL no_restart: busy=%b sh_rst=%b required 0 0", busy_o, sh_rst_o);
      end
   endtask

   initial begin
      test_reset();
      test_code_aaa();
      test_min_timing();
      test_overrun();
      test_ready_in_done();
      test_start_held();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
